// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Brief    : Instruction-fetch stage with a single outstanding imem request and
//            a one-entry instruction buffer feeding the IF/ID register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             redirect,
  input  logic [31:0]      redirect_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      PCOut,
  output logic [31:0]      instOut,
  output logic             fetch_valid,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic [31:0]      r_buf_inst, w_buf_inst_nxt;
  logic             r_drop, w_drop_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [31:0]      w_target;
  logic [31:0]      w_pc_plus4;
  logic             w_full;

  assign w_target   = {redirect_target[31:2], 2'b00};
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_full     = (r_state == S_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_buf_inst <= 32'h0000_0000;
      r_drop     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_buf_inst <= w_buf_inst_nxt;
      r_drop     <= w_drop_nxt;
      r_count    <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_buf_inst_nxt = r_buf_inst;
    w_drop_nxt     = r_drop;
    w_count_nxt    = r_count;
    case (r_state)
      S_REQ: begin
        if (redirect) begin
          w_pc_nxt = w_target;
          if (imem_gnt) begin
            // The granted fetch targets the old pc; its response must be dropped.
            w_state_nxt = S_WAIT;
            w_drop_nxt  = 1'b1;
          end
        end else if (imem_gnt) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_pc_nxt = w_target;
          if (imem_rvalid) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (r_drop) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_buf_inst_nxt = imem_rdata;
            w_state_nxt    = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (!freeze) begin
          w_pc_nxt    = w_pc_plus4;
          w_count_nxt = r_count + 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // Request is masked while reset is held so nothing is issued before release.
  assign imem_req    = reset && (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign fetch_valid = w_full;
  assign PCOut       = w_full ? w_pc_plus4 : 32'h0000_0000;
  assign instOut     = w_full ? r_buf_inst : 32'h0000_0000;
  assign fetch_count = r_count;

endmodule

`default_nettype wire
